// File: rtl/move_sequencer.sv
// Queues cube move codes from the solver and issues them one at a time to the
// stepper move stage, holding each code for the full move plus a settle pause.
//
// state     | meaning
// IDLE      | waiting for run and a queued move
// START     | latch head code onto next_move, pop, pulse move_start
// WAIT_ACK  | waiting for move_done to fall (bounded by ACK_TIMEOUT)
// WAIT_DONE | move in progress, waiting for move_done to rise
// PAUSE     | settle time after a completed move
`timescale 1ns/1ps
module move_sequencer #(
  parameter int DEPTH        = 16,
  parameter int PAUSE_CYCLES = 1000000,
  parameter int ACK_TIMEOUT  = 4000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              move_in,
  input  logic                    move_valid,
  output logic                    move_ready,
  input  logic                    run,
  input  logic                    flush,
  output logic [3:0]              next_move,
  output logic                    move_start,
  input  logic                    move_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    bad_move,
  output logic                    stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PAUSE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FULL       = (AW + 1)'(DEPTH);
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_CYCLES);
  localparam logic [TW-1:0] ACK_LOAD   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, PAUSE} state_t;

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] pause_cnt;
  logic [TW-1:0] ack_cnt;
  logic          accept;
  logic          legal;
  logic          illegal;
  logic          push;
  logic          pop;

  assign move_ready = (count != FULL) && !flush;
  assign accept     = move_valid && move_ready;
  assign legal      = (move_in >= 4'd2) && (move_in <= 4'd13);
  assign illegal    = (move_in <= 4'd1) || (move_in == 4'd14);
  assign push       = accept && legal;
  assign pop        = (state == START);
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= move_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bad_move <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bad_move <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push && count != '0)
        count <= count - 1'b1;
      if (accept && illegal) bad_move <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      next_move  <= 4'hF;
      move_start <= 1'b0;
      pause_cnt  <= '0;
      ack_cnt    <= '0;
      stall      <= 1'b0;
    end else begin
      move_start <= 1'b0;
      if (flush) stall <= 1'b0;
      case (state)
        // a flush on this edge empties the FIFO, so do not commit to a START
        IDLE: if (run && count != '0 && !flush) state <= START;
        START: begin
          next_move  <= mem[rd_ptr];
          move_start <= 1'b1;
          ack_cnt    <= ACK_LOAD;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!move_done) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == '0) begin
            stall <= 1'b1;
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (move_done) begin
            pause_cnt <= PAUSE_LOAD;
            state     <= PAUSE;
          end
        end
        PAUSE: begin
          if (pause_cnt != '0) pause_cnt <= pause_cnt - 1'b1;
          if (pause_cnt <= PW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: vector table, directed multi-cycle sequences and a
// randomized run against a queue-based reference of the move stream.
`timescale 1ns/1ps
module tb_move_sequencer;
  localparam int DEPTH = 4;
  localparam int PAUSE = 3;
  localparam int ACK   = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] move_in = 4'd0;
  logic       move_valid = 1'b0;
  logic       run = 1'b0;
  logic       flush = 1'b0;
  logic       move_done = 1'b1;
  logic       move_ready;
  logic [3:0] next_move;
  logic       move_start;
  logic       busy;
  logic [2:0] count;
  logic       bad_move;
  logic       stall;

  move_sequencer #(.DEPTH(DEPTH), .PAUSE_CYCLES(PAUSE), .ACK_TIMEOUT(ACK)) dut (
    .clock(clock), .reset(reset), .move_in(move_in), .move_valid(move_valid),
    .move_ready(move_ready), .run(run), .flush(flush), .next_move(next_move),
    .move_start(move_start), .move_done(move_done), .busy(busy), .count(count),
    .bad_move(bad_move), .stall(stall));

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  logic [3:0] issued_q[$];
  int start_cyc_q[$];
  int spacing_q[$];
  int rise_edge = -1;
  logic prev_start = 1'b0;
  logic prev_done = 1'b1;
  logic [3:0] last_issued = 4'hF;
  logic stage_hold = 1'b0;
  int ms_k = -1;

  logic [3:0] exp_q[$];
  bit exp_bad = 1'b0;

  typedef struct {
    logic [3:0] code;
    bit         ready;
    int         cnt;
    bit         bad;
  } vec_t;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  function automatic int iq(input int i);
    return (i < issued_q.size()) ? int'(issued_q[i]) : -1;
  endfunction

  task automatic write(input logic [3:0] code);
    int guard = 0;
    move_in = code;
    move_valid = 1'b1;
    #1;
    while (!move_ready && guard < 200) begin
      step();
      #1;
      guard++;
    end
    check("write_ready", int'(move_ready), 1);
    step();
    move_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int i = 0;
    while ((busy || count != 3'd0) && i < bound) begin
      step();
      i++;
    end
    check({name, "_drain"}, int'(i < bound), 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_done_low(input int bound);
    int i = 0;
    while (move_done && i < bound) begin
      step();
      i++;
    end
    check("wait_done_low", int'(i < bound), 1);
  endtask

  // one randomized cycle against the reference queue; quiet=1 drains without new traffic
  task automatic rnd_cycle(input bit quiet);
    bit pred;
    bit p_acc;
    bit p_flush;
    logic [3:0] p_code;
    if (quiet) begin
      run = 1'b1;
      flush = 1'b0;
      move_valid = 1'b0;
    end else begin
      run = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 39) == 0);
      move_valid = 1'($urandom_range(0, 1));
      move_in = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(2, 13));
    end
    #1;
    pred = (exp_q.size() < DEPTH) && !flush;
    check("rnd_ready", int'(move_ready), int'(pred));
    p_acc = move_valid && pred;
    p_code = move_in;
    p_flush = flush;
    step();
    if (move_start) begin
      check("rnd_issue_avail", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("rnd_issue_code", int'(next_move), int'(exp_q.pop_front()));
    end
    if (p_acc && p_code >= 4'd2 && p_code <= 4'd13) exp_q.push_back(p_code);
    if (p_acc && (p_code <= 4'd1 || p_code == 4'd14)) exp_bad = 1'b1;
    if (p_flush) begin
      exp_q.delete();
      exp_bad = 1'b0;
    end
    check("rnd_count", int'(count), exp_q.size());
    check("rnd_bad", int'(bad_move), int'(exp_bad));
    check("rnd_stall", int'(stall), 0);
  endtask

  // move stage: drops move_done 2 cycles after a start, raises it 5 cycles later
  initial forever begin
    @(posedge clock);
    #1;
    if (move_start) ms_k = 0;
    else if (ms_k >= 0) ms_k++;
    if (stage_hold) ms_k = -1;
    else if (ms_k == 2) move_done = 1'b0;
    else if (ms_k == 7) begin
      move_done = 1'b1;
      ms_k = -1;
    end
  end

  // start-pulse monitor: width, code hold between starts, done-rise to start spacing
  initial forever begin
    @(posedge clock);
    #3;
    if (reset) last_issued = 4'hF;
    if (move_done && !prev_done) rise_edge = cyc + 1;
    if (move_start) begin
      check("start_width", int'(prev_start), 0);
      issued_q.push_back(next_move);
      start_cyc_q.push_back(cyc);
      if (rise_edge >= 0) spacing_q.push_back(cyc - rise_edge);
      rise_edge = -1;
      last_issued = next_move;
    end else begin
      check("next_move_hold", int'(next_move), int'(last_issued));
    end
    prev_start = move_start;
    prev_done = move_done;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic [3:0] wrap_codes[6];
    int w_edge;
    int i;

    vt[0] = '{4'd15, 1'b1, 0, 1'b0};
    vt[1] = '{4'd2,  1'b1, 1, 1'b0};
    vt[2] = '{4'd0,  1'b1, 1, 1'b1};
    vt[3] = '{4'd13, 1'b1, 2, 1'b1};
    vt[4] = '{4'd14, 1'b1, 2, 1'b1};
    vt[5] = '{4'd1,  1'b1, 2, 1'b1};
    vt[6] = '{4'd7,  1'b1, 3, 1'b1};
    vt[7] = '{4'd9,  1'b1, 4, 1'b1};
    vt[8] = '{4'd5,  1'b0, 4, 1'b1};
    wrap_codes = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10};

    // reset values
    #1 reset = 1'b1;
    #2;
    check("rst_next_move", int'(next_move), 15);
    check("rst_move_start", int'(move_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_bad", int'(bad_move), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_ready", int'(move_ready), 1);
    steps(2);
    reset = 1'b0;
    steps(2);

    // three moves back to back
    issued_q.delete(); start_cyc_q.delete(); spacing_q.delete(); rise_edge = -1;
    run = 1'b1;
    write(4'd2);
    w_edge = cyc;
    write(4'd4);
    write(4'd13);
    wait_drain(200, "seq1");
    check("seq1_n", issued_q.size(), 3);
    check("seq1_m0", iq(0), 2);
    check("seq1_m1", iq(1), 4);
    check("seq1_m2", iq(2), 13);
    check("seq1_latency", (start_cyc_q.size() > 0) ? start_cyc_q[0] - w_edge : -1, 2);
    check("seq1_nspacing", spacing_q.size(), 2);
    for (int k = 0; k < spacing_q.size(); k++) check("seq1_spacing", spacing_q[k], PAUSE + 2);
    check("seq1_count", int'(count), 0);

    // vector table with run low: filtering, fill to full, rejected fifth write
    run = 1'b0;
    issued_q.delete();
    for (int k = 0; k < 9; k++) begin
      move_in = vt[k].code;
      move_valid = 1'b1;
      #1;
      check($sformatf("tbl_ready[%0d]", k), int'(move_ready), int'(vt[k].ready));
      step();
      move_valid = 1'b0;
      check($sformatf("tbl_count[%0d]", k), int'(count), vt[k].cnt);
      check($sformatf("tbl_bad[%0d]", k), int'(bad_move), int'(vt[k].bad));
    end
    check("tbl_no_start", issued_q.size(), 0);
    run = 1'b1;
    wait_drain(200, "seq2");
    check("seq2_m0", iq(0), 2);
    check("seq2_m1", iq(1), 13);
    check("seq2_m2", iq(2), 7);
    check("seq2_m3", iq(3), 9);
    issued_q.delete();
    for (int k = 0; k < 6; k++) write(wrap_codes[k]);
    wait_drain(300, "wrap");
    check("wrap_n", issued_q.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("wrap_m%0d", k), iq(k), int'(wrap_codes[k]));
    pulse_flush();
    check("flush_clears_bad", int'(bad_move), 0);

    // NULL and illegal codes never issue
    issued_q.delete();
    write(4'd15);
    check("null_count", int'(count), 0);
    check("null_bad", int'(bad_move), 0);
    write(4'd0);
    check("zero_bad", int'(bad_move), 1);
    check("zero_count", int'(count), 0);
    steps(10);
    check("discard_no_start", issued_q.size(), 0);
    check("discard_busy", int'(busy), 0);
    pulse_flush();

    // ACK timeout: move_done never falls
    stage_hold = 1'b1;
    issued_q.delete();
    write(4'd6);
    write(4'd11);
    i = 0;
    while (!move_start && i < 20) begin
      step();
      i++;
    end
    check("stall_start_seen", int'(move_start), 1);
    steps(ACK - 1);
    check("stall_early", int'(stall), 0);
    check("stall_busy_early", int'(busy), 1);
    step();
    check("stall_set", int'(stall), 1);
    check("stall_idle", int'(busy), 0);
    check("stall_count", int'(count), 1);
    stage_hold = 1'b0;
    steps(2);
    check("after_stall_start", int'(move_start), 1);
    check("after_stall_code", int'(next_move), 11);
    wait_drain(100, "stall");
    check("stall_sticky", int'(stall), 1);
    pulse_flush();
    check("flush_clears_stall", int'(stall), 0);

    // flush during WAIT_DONE with three entries queued
    run = 1'b0;
    issued_q.delete();
    write(4'd3); write(4'd5); write(4'd7); write(4'd8);
    run = 1'b1;
    wait_done_low(40);
    step();
    check("fl_count_before", int'(count), 3);
    flush = 1'b1;
    move_valid = 1'b1;
    move_in = 4'd10;
    #1;
    check("fl_ready_low", int'(move_ready), 0);
    step();
    flush = 1'b0;
    move_valid = 1'b0;
    check("fl_count_after", int'(count), 0);
    check("fl_still_busy", int'(busy), 1);
    wait_drain(100, "fl");
    steps(20);
    check("fl_n_issued", issued_q.size(), 1);
    check("fl_code", iq(0), 3);
    check("fl_move_completed", int'(move_done), 1);
    check("fl_idle", int'(busy), 0);

    // randomized traffic against the reference queue
    pulse_flush();
    exp_q.delete();
    exp_bad = 1'b0;
    for (int t = 0; t < 600; t++) rnd_cycle(1'b0);
    i = 0;
    while ((exp_q.size() > 0 || busy) && i < 1000) begin
      rnd_cycle(1'b1);
      i++;
    end
    check("rnd_drained", int'(i < 1000), 1);
    check("rnd_final_count", int'(count), 0);

    // asynchronous reset in WAIT_DONE
    pulse_flush();
    run = 1'b1;
    write(4'd12);
    write(4'd13);
    wait_done_low(40);
    step();
    check("pre_reset_count", int'(count), 1);
    check("pre_reset_code", int'(next_move), 12);
    #4;
    reset = 1'b1;
    #1;
    check("arst_next_move", int'(next_move), 15);
    check("arst_busy", int'(busy), 0);
    check("arst_count", int'(count), 0);
    check("arst_start", int'(move_start), 0);
    check("arst_ready", int'(move_ready), 1);
    steps(2);
    reset = 1'b0;
    steps(12);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Buffers a stream of 4-bit cube move codes from the solver/host side and issues them one at a time to the stepper move stage, the block that drives `next_move`/`move_start` and consumes `move_done`. It holds each code stable for the whole mechanical move, waits for the move to complete, and inserts a settle pause before the next move. It also drops invalid codes and flags a stalled downstream stage.

## Interface
- `DEPTH`, 16, number of FIFO entries; must be a power of 2, at least 2.
- `PAUSE_CYCLES`, 1000000, settle cycles after each completed move (10 ms at 100 MHz); at least 1.
- `ACK_TIMEOUT`, 4000000, cycles to wait for `move_done` to fall after a start pulse.
- `clock` in 1: system clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `move_in` in 4: move code; 2..13 are R,Ri,U,Ui,F,Fi,L,Li,B,Bi,D,Di; 15 is NULL.
- `move_valid` in 1: `move_in` valid this cycle.
- `move_ready` out 1: high when FIFO is not full and `flush` is low.
- `run` in 1: level enable for issuing moves.
- `flush` in 1: discards all queued moves.
- `next_move` out 4: registered code to the move stage.
- `move_start` out 1: single-cycle start pulse.
- `move_done` in 1: move stage done; high when idle, low while a move runs.
- `busy` out 1: high whenever the state is not IDLE.
- `count` out log2(DEPTH)+1: number of FIFO entries.
- `bad_move` out 1: sticky; an illegal code (0, 1 or 14) was received.
- `stall` out 1: sticky; ACK timeout occurred.

## Operation
- Write handshake: a write is accepted when `move_valid & move_ready`.
  - Codes 2..13 are stored.
  - Code 15 is consumed and silently discarded.
  - Codes 0, 1 and 14 are consumed, discarded, and set `bad_move`.
- FIFO: circular buffer with read and write pointers that wrap modulo DEPTH.
  - A write when full is impossible because `move_ready` is low.
  - A write and a pop in the same cycle are both performed and `count` is unchanged.
- `flush`: empties the FIFO on the next edge and clears both sticky flags.
  - It does not abort a move in flight; the FSM finishes its current state sequence.
  - A write coinciding with `flush` is not accepted.
- FSM states:
  - IDLE: if `run` is high and `count` is at least 1, go to START.
  - START: register `next_move` from the FIFO head, pop, pulse `move_start` high for exactly this one cycle, then go to WAIT_ACK.
  - WAIT_ACK: if `move_done` is 0, go to WAIT_DONE. If `ACK_TIMEOUT` cycles elapse with `move_done` still 1, set `stall` and go to IDLE.
  - WAIT_DONE: if `move_done` is 1, load the pause counter with `PAUSE_CYCLES` and go to PAUSE.
  - PAUSE: decrement the counter; at 0, go to IDLE.
- `next_move` holds its value from START until the next START. The move stage derives direction combinationally from it, so it must never change mid-move.
- Dropping `run` mid-move does not interrupt the move; the FSM stops at the next IDLE.
- After `stall`, sequencing continues normally; the flag is for host visibility only.
- Counters are sized by `$clog2` of their maximum value plus 1 and saturate at 0; there is no wrap.

## Timing
- Reset values:
  - `next_move` = 4'd15 (NULL).
  - `move_start` = 0.
  - `busy` = 0.
  - `count` = 0.
  - `bad_move` = 0.
  - `stall` = 0.
  - `move_ready` = 1.
  - State IDLE, pointers 0.
- Latency: a write accepted at edge N into an empty FIFO with `run` high produces `count` = 1 after N. At edge N+1 the FSM enters START, and `move_start`/`next_move` are visible after edge N+2.
- `move_start` is exactly 1 cycle wide. It is never reasserted until at least PAUSE_CYCLES+2 cycles after `move_done` rises.
- Move-to-move spacing: from the rising edge of `move_done` to the next `move_start` is PAUSE_CYCLES+2 cycles, provided the FIFO is non-empty.
- `move_ready` is combinational from `count` and `flush`.
- Reset asserted mid-move forces IDLE and NULL immediately (asynchronous), regardless of `move_done`.

## Test plan
Bench parameters: DEPTH=4, PAUSE_CYCLES=3, ACK_TIMEOUT=8, with a move-stage model that drops `move_done` 2 cycles after start and raises it 5 cycles later.
- Write 2, 4, 13 with `run`=1: three 1-cycle start pulses with `next_move` 2, 4, 13, each held through its move; spacing from `move_done` rise to next start is 5 cycles; `count` ends at 0.
- With `run`=0, write 4 codes: `count`=4 and `move_ready`=0; a fifth write is not accepted; set `run`=1 and all 4 issue in order; check write-pointer wrap with 6 further writes.
- Write 15 then 0: no `move_start` occurs, `count` stays 0, `bad_move`=1 after the code-0 write.
- Model holds `move_done` high: `stall`=1 exactly 8 cycles after the start pulse, state returns to IDLE, and the next queued move issues.
- Pulse `flush` during WAIT_DONE with 3 entries queued: `count`=0, the current move completes, no further start; a simultaneous write is rejected.
- Assert `reset` in WAIT_DONE: `next_move`=15, `busy`=0, `count`=0 immediately, with no clock edge needed.
